// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron trainer: FSM states, DELTA
// encodings, truth-table size and the sample-shuffle LFSR step function.
package perceptron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] DELTA_ZERO = 2'b00;
  localparam logic [1:0] DELTA_POS  = 2'b01;
  localparam logic [1:0] DELTA_NEG  = 2'b11;

  localparam int NUM_SAMPLES = 4;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  // Fibonacci step for x^4 + x^3 + 1: shift left, feed back the two top taps.
  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/sample_lfsr.sv
// 4-bit LFSR that picks the per-epoch sample permutation; o_next_sel is the
// low two bits of the value the register takes at the coming edge.
module sample_lfsr
  import perceptron_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_load,
  input  logic       i_en,
  output logic [1:0] o_next_sel
);

  logic [3:0] r_lfsr;
  logic [3:0] w_next;

  always_comb begin
    w_next = r_lfsr;
    if (i_load) begin
      w_next = LFSR_SEED;
    end else if (i_en) begin
      w_next = lfsr_next(r_lfsr);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign o_next_sel = w_next[1:0];

endmodule

// File: rtl/perceptron_trainer.sv
// Teacher for the single-layer perceptron core: plays the 4-entry truth table
// once per epoch until an error-free epoch or MAX_EPOCHS. Optional sample
// shuffling is enabled with `define PERC_TRAINER_SHUFFLE_EN.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int MAX_EPOCHS = 15,
  parameter int EPOCH_W    = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [3:0]         FUNC,
  input  logic               Z,
  input  logic [1:0]         DELTA,
  output logic               X1,
  output logic               X2,
  output logic               S,
  output logic               BUSY,
  output logic               DONE,
  output logic               FAIL,
  output logic [EPOCH_W-1:0] EPOCH,
  output logic [2:0]         ERR_CNT
);

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_func;
  logic [1:0]         r_idx;
  logic [2:0]         r_acc;
  logic [2:0]         r_err_cnt;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_x1;
  logic               r_x2;
  logic               r_s;

  logic               w_train;
  logic               w_start;
  logic               w_epoch_end;
  logic               w_err;
  logic [2:0]         w_err_final;
  logic [EPOCH_W-1:0] w_epoch_inc;
  logic               w_last;
  logic [1:0]         w_next_idx;
  logic [1:0]         w_pres_idx;
  logic [3:0]         w_func;

  assign w_train     = (r_state == ST_TRAIN);
  assign w_start     = START && !w_train;
  assign w_epoch_end = w_train && (r_idx == 2'(NUM_SAMPLES - 1));
  // The illegal 2'b10 code is treated as an error like any other nonzero value.
  assign w_err       = (DELTA != DELTA_ZERO);
  assign w_err_final = r_acc + {2'b00, w_err};
  assign w_epoch_inc = r_epoch + 1'b1;
  assign w_last      = (w_epoch_inc == EPOCH_W'(MAX_EPOCHS));
  assign w_next_idx  = w_start ? 2'd0 : r_idx + 2'd1;
  assign w_func      = w_start ? FUNC : r_func;

`ifdef PERC_TRAINER_SHUFFLE_EN
  logic [1:0] w_lfsr_sel;

  sample_lfsr u_lfsr (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_load     (w_start),
    .i_en       (w_epoch_end),
    .o_next_sel (w_lfsr_sel)
  );

  assign w_pres_idx = w_next_idx ^ w_lfsr_sel;
`else
  assign w_pres_idx = w_next_idx;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_TRAIN: begin
        if (w_epoch_end) begin
          if (w_err_final == 3'd0) begin
            w_next_state = ST_DONE;
          end else if (w_last) begin
            w_next_state = ST_FAIL;
          end
        end
      end
      default: begin
        if (START) begin
          w_next_state = ST_TRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx     <= 2'd0;
      r_acc     <= 3'd0;
      r_err_cnt <= 3'd0;
      r_epoch   <= '0;
      r_x1      <= 1'b0;
      r_x2      <= 1'b0;
      r_s       <= 1'b0;
    end else begin
      if (w_start) begin
        r_idx   <= 2'd0;
        r_acc   <= 3'd0;
        r_epoch <= '0;
      end else if (w_train) begin
        r_idx <= w_next_idx;
        if (w_epoch_end) begin
          r_err_cnt <= w_err_final;
          r_epoch   <= w_epoch_inc;
          r_acc     <= 3'd0;
        end else begin
          r_acc <= w_err_final;
        end
      end
      // Sample presented next cycle; zeros in hold so the core sees no input.
      if (w_next_state == ST_TRAIN) begin
        r_x1 <= w_pres_idx[1];
        r_x2 <= w_pres_idx[0];
        r_s  <= w_func[w_pres_idx];
      end else begin
        r_x1 <= 1'b0;
        r_x2 <= 1'b0;
        r_s  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_start) begin
      r_func <= FUNC;
    end
  end

  assign X1      = r_x1;
  assign X2      = r_x2;
  // Echoing Z back as the target forces DELTA to zero, freezing the weights.
  assign S       = w_train ? r_s : Z;
  assign BUSY    = w_train;
  assign DONE    = (r_state == ST_DONE);
  assign FAIL    = (r_state == ST_FAIL);
  assign EPOCH   = r_epoch;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench: trainer driving a behavioural perceptron core; a reference training
// model fills a sample scoreboard that is drained on every TRAIN cycle.
`timescale 1ns/1ps
module tb_perceptron_trainer;

  localparam int MAXE = 15;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0;
  logic [3:0] FUNC  = 4'b0000;
  logic       Z;
  logic [1:0] DELTA;
  logic       X1, X2, S, BUSY, DONE, FAIL;
  logic [3:0] EPOCH;
  logic [2:0] ERR_CNT;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic x1;
    logic x2;
    logic s;
  } smp_t;

  smp_t exp_q[$];
  smp_t mon_got;
  smp_t mon_want;

  int   w1 = 0, w2 = 0, w3 = 0;
  int   ld1 = 1, ld2 = 2, ld3 = 0;
  logic core_load = 1'b0;
  logic force10   = 1'b0;
  int   sum;
  int   d_int;

  always #5 CLK = ~CLK;

  perceptron_trainer #(.MAX_EPOCHS(MAXE), .EPOCH_W(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .FUNC    (FUNC),
    .Z       (Z),
    .DELTA   (DELTA),
    .X1      (X1),
    .X2      (X2),
    .S       (S),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .FAIL    (FAIL),
    .EPOCH   (EPOCH),
    .ERR_CNT (ERR_CNT)
  );

  // Behavioural perceptron core: Z = step(w1*x1 + w2*x2 + w3), DELTA = S - Z.
  assign sum   = (X1 ? w1 : 0) + (X2 ? w2 : 0) + w3;
  assign Z     = (sum > 0);
  assign d_int = int'(S) - int'(Z);
  assign DELTA = force10 ? 2'b10 : 2'(d_int);

  always @(posedge CLK) begin
    if (core_load) begin
      w1 <= ld1;
      w2 <= ld2;
      w3 <= ld3;
    end else if (!force10) begin
      w1 <= w1 + (X1 ? d_int : 0);
      w2 <= w2 + (X2 ? d_int : 0);
      w3 <= w3 + d_int;
    end
  end

  always @(negedge CLK) begin
    if (RST_N && BUSY) begin
      mon_got = {X1, X2, S};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample: unexpected TRAIN cycle, got x1x2s=%b, required none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL sample: got x1x2s=%b, required %b at %0t", mon_got, mon_want, $time);
        end
      end
    end
  end

  task automatic model_run(input logic [3:0] f, input bit f10, output int ep, output int ec);
    int a, b, c, z, d;
    logic [1:0] idx;
`ifdef PERC_TRAINER_SHUFFLE_EN
    logic [3:0] lf;
    lf = 4'b1001;
`endif
    a = w1; b = w2; c = w3;
    ep = 0; ec = 0;
    for (int e = 1; e <= MAXE; e++) begin
      ec = 0;
      for (int k = 0; k < 4; k++) begin
        idx = 2'(k);
`ifdef PERC_TRAINER_SHUFFLE_EN
        idx = idx ^ lf[1:0];
`endif
        z = (((idx[1] ? a : 0) + (idx[0] ? b : 0) + c) > 0) ? 1 : 0;
        d = int'(f[idx]) - z;
        if (f10 || d != 0) ec++;
        if (!f10) begin
          a += idx[1] ? d : 0;
          b += idx[0] ? d : 0;
          c += d;
        end
        exp_q.push_back({idx[1], idx[0], f[idx]});
      end
      ep = e;
`ifdef PERC_TRAINER_SHUFFLE_EN
      lf = {lf[2:0], lf[3] ^ lf[2]};
`endif
      if (ec == 0) break;
    end
  endtask

  task automatic load_core(input int a, input int b, input int c);
    ld1 = a; ld2 = b; ld3 = c;
    core_load = 1'b1;
    @(posedge CLK); #1;
    core_load = 1'b0;
  endtask

  task automatic kick(input logic [3:0] f, input bit f10, output int ep, output int ec);
    FUNC    = f;
    force10 = f10;
    model_run(f, f10, ep, ec);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_until_idle(input int pulse_at, input logic [3:0] func_during,
                                output int cyc, output bit tmo);
    cyc = 0;
    while (BUSY && cyc < 300) begin
      if (cyc == pulse_at) begin
        START = 1'b1;
        FUNC  = func_during;
      end else begin
        START = 1'b0;
      end
      cyc++;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    tmo = BUSY;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    load_core(1, 2, 0);
    checks++;
    if ({BUSY, DONE, FAIL, X1, X2, EPOCH, ERR_CNT} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy/done/fail/x1/x2/epoch/err=%b, required 0",
               {BUSY, DONE, FAIL, X1, X2, EPOCH, ERR_CNT});
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      checks++;
      if (X1 !== 1'b0 || X2 !== 1'b0 || S !== Z || DELTA !== 2'b00 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d got x1=%b x2=%b s=%b z=%b delta=%b busy=%b, required 0 0 s==z 00 0",
                 i, X1, X2, S, Z, DELTA, BUSY);
      end
    end
    checks++;
    if (w1 != 1 || w2 != 2 || w3 != 0) begin
      errors++;
      $display("FAIL idle_weights: got %0d/%0d/%0d, required 1/2/0", w1, w2, w3);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_and();
    int ep, ec, cyc;
    bit tmo;
    kick(4'b1000, 1'b0, ep, ec);
    run_until_idle(-1, 4'b1000, cyc, tmo);
    checks++;
    if (tmo || DONE !== 1'b1 || FAIL !== 1'b0 || ERR_CNT !== 3'd0) begin
      errors++;
      $display("FAIL and_done: got tmo=%0d done=%b fail=%b err=%0d, required 0 1 0 0", tmo, DONE, FAIL, ERR_CNT);
    end
    checks++;
    if (EPOCH !== 4'(ep) || EPOCH > 4'd15 || cyc != 4 * ep) begin
      errors++;
      $display("FAIL and_epochs: got epoch=%0d cycles=%0d, required epoch=%0d cycles=%0d", EPOCH, cyc, ep, 4 * ep);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL and_drain: got %0d samples left, required 0", exp_q.size());
      exp_q.delete();
    end
    kick(4'b1000, 1'b0, ep, ec);
    run_until_idle(-1, 4'b1000, cyc, tmo);
    checks++;
    if (tmo || DONE !== 1'b1 || EPOCH !== 4'd1 || ERR_CNT !== 3'd0 || cyc != 4) begin
      errors++;
      $display("FAIL and_rerun: got done=%b epoch=%0d err=%0d cycles=%0d, required 1 1 0 4", DONE, EPOCH, ERR_CNT, cyc);
    end
  endtask

  task automatic test_xor();
    int ep, ec, cyc;
    bit tmo;
    kick(4'b0110, 1'b0, ep, ec);
    run_until_idle(-1, 4'b0110, cyc, tmo);
    checks++;
    if (tmo || FAIL !== 1'b1 || DONE !== 1'b0 || EPOCH !== 4'd15 || cyc != 60) begin
      errors++;
      $display("FAIL xor_fail: got fail=%b done=%b epoch=%0d cycles=%0d, required 1 0 15 60", FAIL, DONE, EPOCH, cyc);
    end
    checks++;
    if (ERR_CNT !== 3'(ec) || ERR_CNT == 3'd0) begin
      errors++;
      $display("FAIL xor_errcnt: got %0d, required %0d (nonzero)", ERR_CNT, ec);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL xor_drain: got %0d samples left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_start_ignored();
    int ep, ec, cyc;
    bit tmo;
    load_core(1, 2, 0);
    kick(4'b1000, 1'b0, ep, ec);
    run_until_idle(4, 4'b0110, cyc, tmo);
    checks++;
    if (tmo || DONE !== 1'b1 || EPOCH !== 4'(ep) || ERR_CNT !== 3'd0 || cyc != 4 * ep) begin
      errors++;
      $display("FAIL start_ignored: got done=%b epoch=%0d err=%0d cycles=%0d, required 1 %0d 0 %0d",
               DONE, EPOCH, ERR_CNT, cyc, ep, 4 * ep);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_ignored_drain: got %0d samples left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int ep, ec, cyc;
    bit tmo;
    load_core(1, 2, 0);
    kick(4'b0110, 1'b0, ep, ec);
    repeat (6) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (BUSY !== 1'b1 || EPOCH !== 4'd1) begin
      errors++;
      $display("FAIL mid_setup: got busy=%b epoch=%0d, required 1 1", BUSY, EPOCH);
    end
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || EPOCH !== 4'd0 || X1 !== 1'b0 || X2 !== 1'b0 || ERR_CNT !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b epoch=%0d x1=%b x2=%b err=%0d, required 0 0 0 0 0",
               BUSY, EPOCH, X1, X2, ERR_CNT);
    end
    exp_q.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || FAIL !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b done=%b fail=%b, required 0 0 0", BUSY, DONE, FAIL);
    end
    kick(4'b1000, 1'b0, ep, ec);
    run_until_idle(-1, 4'b1000, cyc, tmo);
    checks++;
    if (tmo || DONE !== 1'b1 || EPOCH !== 4'(ep) || cyc != 4 * ep || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_restart: got done=%b epoch=%0d cycles=%0d left=%0d, required 1 %0d %0d 0",
               DONE, EPOCH, cyc, exp_q.size(), ep, 4 * ep);
      exp_q.delete();
    end
  endtask

  task automatic test_delta_illegal();
    int ep, ec, cyc;
    bit tmo;
    load_core(1, 2, 0);
    kick(4'b1000, 1'b1, ep, ec);
    run_until_idle(-1, 4'b1000, cyc, tmo);
    force10 = 1'b0;
    checks++;
    if (tmo || FAIL !== 1'b1 || ERR_CNT !== 3'd4 || EPOCH !== 4'd15 || cyc != 60) begin
      errors++;
      $display("FAIL delta10: got fail=%b err=%0d epoch=%0d cycles=%0d, required 1 4 15 60",
               FAIL, ERR_CNT, EPOCH, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL delta10_drain: got %0d samples left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor();
    test_start_ignored();
    test_reset_mid();
    test_delta_illegal();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Initiator/teacher for the single-layer perceptron core. It drives the sample stream (X1, X2, S) and watches the core's DELTA and Z responses.
- Sequences epochs over the 4-entry truth table of a 2-input boolean function, counts errors per epoch, detects convergence or gives up.
- Sits between top-level control (START/FUNC) and the perceptron core. The core updates weights every CLK edge.

Parameters:
- MAX_EPOCHS, 15, epoch limit before FAIL (1..15; EPOCH output is 4 bits)
- EPOCH_W, 4, width of the epoch counter/output

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  one-cycle pulse; begins training when not busy
- FUNC  input  4  target truth table; FUNC[i] is the target for sample i, with i = {X1,X2}
- Z  input  1  core output (step of MAC), combinational from X1/X2 and weights
- DELTA  input  2  core error S−Z, two's complement: 00=0, 01=+1, 11=−1 (10 never legal)
- X1  output  1  sample input 1 to core
- X2  output  1  sample input 2 to core
- S  output  1  target to core
- BUSY  output  1  high in TRAIN
- DONE  output  1  high in DONE state (converged)
- FAIL  output  1  high in FAIL state (limit reached without convergence)
- EPOCH  output  EPOCH_W  epochs completed in current/last run
- ERR_CNT  output  3  nonzero-DELTA count of the last completed epoch (0..4)

Behaviour:
- States: IDLE, TRAIN, DONE, FAIL. Reset → IDLE; EPOCH=0, ERR_CNT=0, X1=X2=0, BUSY=DONE=FAIL=0.
- Hold mode (IDLE/DONE/FAIL): X1=X2=0 registered; S=Z combinationally. This forces DELTA=0 so core weights freeze. No combinational loop, since Z does not depend on S.
- IDLE: START → latch FUNC, idx=0, EPOCH=0, epoch error accumulator=0 → TRAIN.
- TRAIN, one sample per cycle:
  - X1=idx[1], X2=idx[0], S=FUNC_latched[idx], all registered.
  - DELTA is sampled in the same cycle the sample is presented (zero latency; path goes through the core's combinational logic). Weight update occurs at that cycle's closing edge.
  - acc increments when DELTA≠00. idx increments, wrapping 3→0.
- Epoch end (idx==3 cycle):
  - ERR_CNT ← acc + (DELTA≠0); EPOCH ← EPOCH+1; acc ← 0.
  - If the final count is 0 → DONE.
  - Else if EPOCH+1 == MAX_EPOCHS → FAIL.
  - Else continue TRAIN with idx=0.
- DONE/FAIL: outputs held, hold mode. START → restart as from IDLE. The core keeps its learned weights; the trainer never resets them.
- START while in TRAIN: ignored. FUNC changes in TRAIN: ignored (latched copy used).
- DELTA=10 in TRAIN: counted as an error (nonzero).
- Reset asserted mid-TRAIN: immediate return to IDLE, counters cleared, outputs to reset values.

Optional Feature:
- Macro PERC_TRAINER_SHUFFLE_EN.
- Defined:
  - A 4-bit Fibonacci LFSR (x^4+x^3+1, seed 4'b1001 at reset and on START) advances once per epoch end.
  - Presented index is idx ^ lfsr[1:0], so each epoch visits all 4 samples in a permuted order. ERR_CNT/EPOCH semantics are unchanged.
- Undefined: fixed order 0,1,2,3; no LFSR logic.

Decomposition:
- Package perceptron_pkg: state enum (IDLE/TRAIN/DONE/FAIL), DELTA encoding constants (DELTA_ZERO=2'b00, DELTA_POS=2'b01, DELTA_NEG=2'b11), NUM_SAMPLES=4.
- Sub-module sample_lfsr (4-bit, enable + load), instantiated only under PERC_TRAINER_SHUFFLE_EN.
- Bench top instantiates perceptron_trainer driving the perceptron core.

Test Plan:
- Reset then 50 idle cycles → X1=X2=0, S==Z, DELTA==00 every cycle, core W1=1/W2=2/W3=0 unchanged.
- START with FUNC=4'b1000 (AND) → BUSY for 4·EPOCH cycles; DONE=1 with ERR_CNT=0, EPOCH≤15. A further START converges in exactly 1 epoch (EPOCH=1).
- START with FUNC=4'b0110 (XOR) → FAIL=1 after exactly 60 TRAIN cycles, EPOCH=15, ERR_CNT≥1, DONE=0.
- START pulsed again at TRAIN cycle 5 of an AND run → ignored; epoch/idx sequence identical to the undisturbed run.
- RST_N low for 1 cycle mid-epoch (idx=2) → same cycle BUSY=0, EPOCH=0, X1=X2=0; a later START restarts cleanly at idx=0.
- With PERC_TRAINER_SHUFFLE_EN: log (X1,X2) per epoch → each epoch is a permutation of {00,01,10,11}, with order changing per LFSR sequence from seed 1001.
